// File: rtl/sdr_tx_pkg.sv
// Shared widths and helpers for the AM transmit chain.
package sdr_tx_pkg;

  localparam int unsigned DEF_WIDTH         = 16;
  localparam int unsigned DEF_PHASE_WIDTH   = 32;
  localparam int unsigned DEF_LUT_ADDR      = 8;
  localparam int unsigned DEF_SAMPLE_DIVIDE = 4096;

  // Quadrant control: mirror the table address and/or negate the magnitude.
  typedef struct packed {
    logic mirror;
    logic negate;
  } quad_ctl_t;

  function automatic quad_ctl_t quad_decode(input logic [1:0] q);
    quad_ctl_t c;
    case (q)
      2'd0:    c = '{mirror: 1'b0, negate: 1'b0};
      2'd1:    c = '{mirror: 1'b1, negate: 1'b0};
      2'd2:    c = '{mirror: 1'b0, negate: 1'b1};
      2'd3:    c = '{mirror: 1'b1, negate: 1'b1};
      default: c = '{mirror: 1'b0, negate: 1'b0};
    endcase
    return c;
  endfunction

  // DC-biased envelope: 2^(width-1) + floor(audio * depth / 256).
  function automatic logic [31:0] env_bias(input logic signed [31:0] audio,
                                           input logic [7:0]         depth,
                                           input int unsigned        width);
    logic signed [31:0] prod;
    logic signed [31:0] scaled;
    prod   = audio * $signed({24'd0, depth});
    scaled = prod >>> 8;
    return (32'd1 << (width - 32'd1)) + $unsigned(scaled);
  endfunction

endpackage

// File: rtl/am_tx_sine_lut.sv
// Quarter-wave sine ROM with quadrant mirroring/negation and a registered output.
module am_tx_sine_lut
  import sdr_tx_pkg::*;
#(
  parameter int unsigned WIDTH    = DEF_WIDTH,
  parameter int unsigned LUT_ADDR = DEF_LUT_ADDR
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [LUT_ADDR+1:0]     phase_idx_i,
  output logic signed [WIDTH-1:0] sine_o
);

  localparam int unsigned N   = 1 << LUT_ADDR;
  localparam real         PI  = 3.14159265358979323846;
  localparam real         AMP = (2.0 ** (WIDTH - 1)) - 1.0;

  logic [WIDTH-1:0]        rom_s [0:N];
  quad_ctl_t               qc_s;
  logic [LUT_ADDR:0]       idx_s;
  logic [WIDTH-1:0]        mag_s;
  logic signed [WIDTH-1:0] sine_q;

  // Table built at elaboration: round(AMP * sin(pi/2 * k / N)), k = 0..N.
  for (genvar k = 0; k <= N; k++) begin : g_rom
    localparam real ANG = PI / 2.0 * real'(k) / real'(N);
    assign rom_s[k] = WIDTH'($rtoi(AMP * $sin(ANG) + 0.5));
  end

  // Address mirroring for the odd quadrants.
  always_comb begin
    qc_s = quad_decode(phase_idx_i[LUT_ADDR+1:LUT_ADDR]);
    if (qc_s.mirror) begin
      idx_s = (LUT_ADDR + 1)'(N) - {1'b0, phase_idx_i[LUT_ADDR-1:0]};
    end else begin
      idx_s = {1'b0, phase_idx_i[LUT_ADDR-1:0]};
    end
    mag_s = rom_s[idx_s];
  end

  // Registered carrier sample, negated in the lower half-cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sine_q <= '0;
    end else if (qc_s.negate) begin
      sine_q <= -$signed(mag_s);
    end else begin
      sine_q <= $signed(mag_s);
    end
  end

  assign sine_o = sine_q;

endmodule

// File: rtl/am_transmitter.sv
// AM transmitter: sample handshake/hold, envelope, NCO carrier mixer, 1-bit sigma-delta.
module am_transmitter
  import sdr_tx_pkg::*;
#(
  parameter int unsigned WIDTH         = DEF_WIDTH,
  parameter int unsigned PHASE_WIDTH   = DEF_PHASE_WIDTH,
  parameter int unsigned LUT_ADDR      = DEF_LUT_ADDR,
  parameter int unsigned SAMPLE_DIVIDE = DEF_SAMPLE_DIVIDE
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic [PHASE_WIDTH-1:0]  phase_increment,
  input  logic [7:0]              mod_depth,
  input  logic signed [WIDTH-1:0] data_in,
  input  logic                    data_valid,
  output logic                    data_ready,
  output logic                    underrun,
  output logic                    rf_out
);

  localparam int unsigned             CNT_W    = $clog2(SAMPLE_DIVIDE);
  localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(SAMPLE_DIVIDE - 1);
  localparam logic [WIDTH-1:0]        ENV_MID  = {1'b1, {(WIDTH - 1){1'b0}}};
  localparam logic signed [WIDTH+1:0] SD_STEP  = {3'b001, {(WIDTH - 1){1'b0}}};

  logic [PHASE_WIDTH-1:0]  phase_q;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [WIDTH-1:0] hold_q, hold_d, audio_q, audio_d;
  logic                    hold_full_q, hold_full_d;
  logic                    data_ready_q, underrun_q, underrun_d, env_upd_q;
  logic [7:0]              depth_q, depth_d;
  logic [WIDTH-1:0]        env_q, env_d;
  logic signed [WIDTH-1:0] carrier_s, x_q, x_d;
  logic signed [WIDTH+1:0] err_q, err_d, v_s;
  logic                    rf_q, rf_d, tick_s, xfer_s;
  logic [31:0]             env_full_s;
  logic [2*WIDTH:0]        prod_s;
  logic                    unused_s;

  am_tx_sine_lut #(
    .WIDTH    (WIDTH),
    .LUT_ADDR (LUT_ADDR)
  ) u_lut (
    .clk_i       (clock),
    .rst_ni      (clock_areset_n),
    .phase_idx_i (phase_q[PHASE_WIDTH-1 -: LUT_ADDR + 2]),
    .sine_o      (carrier_s)
  );

  // Tick counter, holding register, underrun and envelope next-state.
  always_comb begin
    tick_s      = (cnt_q == CNT_LAST);
    xfer_s      = data_valid && data_ready_q;
    cnt_d       = tick_s ? '0 : cnt_q + CNT_W'(1);
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    audio_d     = audio_q;
    depth_d     = depth_q;
    if (tick_s) begin
      depth_d = mod_depth;
      if (hold_full_q) begin
        audio_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        audio_d = audio_q;
      end
    end else begin
      depth_d = depth_q;
    end
    // A transfer can only happen when the holding register is empty.
    if (xfer_s) begin
      hold_d      = data_in;
      hold_full_d = 1'b1;
    end else begin
      hold_d = hold_q;
    end
    underrun_d = tick_s && !hold_full_q;
    env_full_s = env_bias({{(32 - WIDTH){audio_q[WIDTH-1]}}, audio_q}, depth_q, WIDTH);
    env_d      = env_upd_q ? env_full_s[WIDTH-1:0] : env_q;
  end

  // Carrier x envelope product and first-order sigma-delta next-state.
  always_comb begin
    // Operands sign/zero-extended to full width so the low bits are the exact signed product.
    prod_s = {{(WIDTH + 1){carrier_s[WIDTH-1]}}, carrier_s} *
             {{(WIDTH + 1){1'b0}}, env_q};
    x_d    = $signed(prod_s[2*WIDTH-1:WIDTH]);
    v_s    = err_q + {{2{x_q[WIDTH-1]}}, x_q};
    rf_d   = ~v_s[WIDTH+1];
    if (rf_d) begin
      err_d = v_s - SD_STEP;
    end else begin
      err_d = v_s + SD_STEP;
    end
  end

  assign unused_s = ^{prod_s[2*WIDTH], prod_s[WIDTH-1:0], env_full_s[31:WIDTH]};

  // All datapath and control state, reset asynchronously.
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      phase_q      <= '0;
      cnt_q        <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      data_ready_q <= 1'b1;
      audio_q      <= '0;
      depth_q      <= 8'd0;
      env_upd_q    <= 1'b0;
      env_q        <= ENV_MID;
      x_q          <= '0;
      err_q        <= '0;
      rf_q         <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      phase_q      <= phase_q + phase_increment;
      cnt_q        <= cnt_d;
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
      data_ready_q <= !hold_full_d;
      audio_q      <= audio_d;
      depth_q      <= depth_d;
      env_upd_q    <= tick_s;
      env_q        <= env_d;
      x_q          <= x_d;
      err_q        <= err_d;
      rf_q         <= rf_d;
      underrun_q   <= underrun_d;
    end
  end

  assign data_ready = data_ready_q;
  assign underrun   = underrun_q;
  assign rf_out     = rf_q;

endmodule
